hsv_wheel_top: RTL and testbench

- Top-level RGB LED colour-wheel driver for a 12 MHz board.
- Sweeps hue through 360 steps, one full revolution per second, at full saturation and full value.
- Converts hue to 8-bit R/G/B intensities and drives three active-low LED pins with 8-bit PWM.
- Hue generation lives in a sub-module instantiated as `hsv_wheel`; the PWM stage and output registers live in the top.

---
 rtl/hsv_wheel_pkg.sv | 31 +++
 rtl/hsv_wheel_gen.sv | 70 +++++++
 rtl/hsv_wheel_top.sv | 47 ++++
 tb/tb_hsv_wheel_top.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hsv_wheel_pkg.sv
// Shared constants, colour type and the region-to-colour mapping for the hue wheel.
package hsv_wheel_pkg;

  localparam int STEPS        = 360;
  localparam int REGION_STEPS = 60;
  localparam int VAL_MAX      = 255;
  localparam int PWM_BITS     = 8;

  typedef struct packed {
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
  } color_t;

  // Six 60-step sectors of the wheel; exactly one channel ramps in each.
  function automatic color_t region_color(input logic [8:0] region, input logic [7:0] rise);
    color_t     c;
    logic [7:0] fall;
    fall = 8'(VAL_MAX) - rise;
    case (region)
      9'd0:    c = '{8'hFF, rise,  8'h00};
      9'd1:    c = '{fall,  8'hFF, 8'h00};
      9'd2:    c = '{8'h00, 8'hFF, rise};
      9'd3:    c = '{8'h00, fall,  8'hFF};
      9'd4:    c = '{rise,  8'h00, 8'hFF};
      default: c = '{8'hFF, 8'h00, fall};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/hsv_wheel_gen.sv
// Hue generator: step prescaler, 0..359 hue counter, sector decode and registered RGB values.
module hsv_wheel_gen
  import hsv_wheel_pkg::*;
#(
  parameter int STEP_CYCLES = 33333
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] red_value,
  output logic [7:0] green_value,
  output logic [7:0] blue_value
);

  localparam int               PRE_W     = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(STEP_CYCLES - 1);
  localparam logic [8:0]       STEP_LAST = 9'(STEPS - 1);

  logic [PRE_W-1:0] prescaler;
  logic [8:0]       step_counter;
  logic [8:0]       region;
  logic [8:0]       region_base;
  logic [8:0]       offset;
  logic [9:0]       ramp_prod;
  logic [7:0]       rise;
  color_t           next_color;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler    <= '0;
      step_counter <= '0;
    end else if (prescaler == PRE_LAST) begin
      prescaler    <= '0;
      step_counter <= (step_counter == STEP_LAST) ? 9'd0 : step_counter + 9'd1;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  // Divide by 60 as a compare chain; the matched boundary doubles as the sector base.
  always_comb begin
    region      = '0;
    region_base = '0;
    for (int i = 1; i < 6; i++) begin
      if (step_counter >= 9'(i * REGION_STEPS)) begin
        region      = 9'(i);
        region_base = 9'(i * REGION_STEPS);
      end
    end
  end

  always_comb begin
    offset     = step_counter - region_base;
    ramp_prod  = 10'(offset) * 10'd17;
    rise       = 8'(ramp_prod >> 2);
    next_color = region_color(region, rise);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      red_value   <= 8'hFF;
      green_value <= 8'h00;
      blue_value  <= 8'h00;
    end else begin
      red_value   <= next_color.red;
      green_value <= next_color.green;
      blue_value  <= next_color.blue;
    end
  end

endmodule

// File: rtl/hsv_wheel_top.sv
// RGB colour-wheel LED driver: hue generator plus 8-bit PWM into registered active-low pins.
module hsv_wheel_top
  import hsv_wheel_pkg::*;
#(
  parameter int CLK_HZ      = 12_000_000,
  parameter int STEPS       = 360,
  parameter int STEP_CYCLES = CLK_HZ / STEPS,
  parameter int PWM_BITS    = 8
) (
  input  logic clk,
  input  logic rst_n,
  output logic RGB_R,
  output logic RGB_G,
  output logic RGB_B
);

  logic [7:0]          red_value;
  logic [7:0]          green_value;
  logic [7:0]          blue_value;
  logic [PWM_BITS-1:0] pwm_cnt;

  hsv_wheel_gen #(
    .STEP_CYCLES(STEP_CYCLES)
  ) hsv_wheel (
    .clk        (clk),
    .rst_n      (rst_n),
    .red_value  (red_value),
    .green_value(green_value),
    .blue_value (blue_value)
  );

  // Registered pins keep the LED drive glitch-free while the compare settles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
      RGB_R   <= 1'b1;
      RGB_G   <= 1'b1;
      RGB_B   <= 1'b1;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      RGB_R   <= ~(pwm_cnt < red_value);
      RGB_G   <= ~(pwm_cnt < green_value);
      RGB_B   <= ~(pwm_cnt < blue_value);
    end
  end

endmodule

// File: tb/tb_hsv_wheel_top.sv
// Directed bench: fast-stepping instance for timing/wrap/reset, slow instance for PWM duty.
module tb_hsv_wheel_top;

  logic clk = 1'b0;
  logic rst_n_a = 1'b0;
  logic rst_n_p = 1'b0;
  logic a_r, a_g, a_b;
  logic p_r, p_g, p_b;
  int   tests = 0;
  int   fails = 0;
  int   p_edges = 0;

  always #5 clk = ~clk;

  hsv_wheel_top #(.STEP_CYCLES(4)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .RGB_R(a_r), .RGB_G(a_g), .RGB_B(a_b)
  );

  hsv_wheel_top #(.STEP_CYCLES(256)) dut_p (
    .clk(clk), .rst_n(rst_n_p), .RGB_R(p_r), .RGB_G(p_g), .RGB_B(p_b)
  );

  always @(posedge clk or negedge rst_n_p) begin
    if (!rst_n_p) p_edges <= 0;
    else          p_edges <= p_edges + 1;
  end

  // Reference colour for a hue step, straight from the divide/modulo description.
  function automatic logic [23:0] exp_color(input int s);
    int rg, off, rise, fall;
    rg   = s / 60;
    off  = s % 60;
    rise = (off * 17) / 4;
    fall = 255 - rise;
    case (rg)
      0:       return {8'd255, 8'(rise), 8'd0};
      1:       return {8'(fall), 8'd255, 8'd0};
      2:       return {8'd0, 8'd255, 8'(rise)};
      3:       return {8'd0, 8'(fall), 8'd255};
      4:       return {8'(rise), 8'd0, 8'd255};
      default: return {8'd255, 8'd0, 8'(fall)};
    endcase
  endfunction

  task automatic test_reset();
    rst_n_a = 1'b0;
    rst_n_p = 1'b0;
    repeat (10) @(negedge clk);
    tests++;
    if ({a_r, a_g, a_b} !== 3'b111) begin
      fails++; $display("FAIL reset_rgb_a got=%b exp=111", {a_r, a_g, a_b});
    end
    tests++;
    if ({p_r, p_g, p_b} !== 3'b111) begin
      fails++; $display("FAIL reset_rgb_p got=%b exp=111", {p_r, p_g, p_b});
    end
    tests++;
    if (dut_a.hsv_wheel.step_counter !== 9'd0) begin
      fails++; $display("FAIL reset_step got=%0d exp=0", dut_a.hsv_wheel.step_counter);
    end
    tests++;
    if ({dut_a.hsv_wheel.red_value, dut_a.hsv_wheel.green_value, dut_a.hsv_wheel.blue_value}
        !== {8'd255, 8'd0, 8'd0}) begin
      fails++; $display("FAIL reset_values got=%0d/%0d/%0d exp=255/0/0",
        dut_a.hsv_wheel.red_value, dut_a.hsv_wheel.green_value, dut_a.hsv_wheel.blue_value);
    end
    tests++;
    if (dut_p.pwm_cnt !== 8'd0 || dut_a.hsv_wheel.region !== 9'd0) begin
      fails++; $display("FAIL reset_pwm_region got=%0d/%0d exp=0/0",
        dut_p.pwm_cnt, dut_a.hsv_wheel.region);
    end
  endtask

  task automatic test_release_pwm();
    int r_low, g_low, b_low;
    r_low = 0; g_low = 0; b_low = 0;
    rst_n_p = 1'b1;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (p_r === 1'b0) r_low++;
      if (p_g === 1'b0) g_low++;
      if (p_b === 1'b0) b_low++;
    end
    tests++;
    if (r_low != 255) begin fails++; $display("FAIL release_r_duty got=%0d exp=255", r_low); end
    tests++;
    if (g_low != 0)   begin fails++; $display("FAIL release_g_duty got=%0d exp=0", g_low); end
    tests++;
    if (b_low != 0)   begin fails++; $display("FAIL release_b_duty got=%0d exp=0", b_low); end
  endtask

  // Per-edge check of step, region and values on the fast instance; edge counted from release.
  task automatic check_a_edge(input int e);
    int          s_now, s_prev;
    logic [23:0] got, exp;
    s_now  = (e / 4) % 360;
    s_prev = ((e - 1) / 4) % 360;
    exp = exp_color(s_prev);
    got = {dut_a.hsv_wheel.red_value, dut_a.hsv_wheel.green_value, dut_a.hsv_wheel.blue_value};
    tests++;
    if (dut_a.hsv_wheel.step_counter !== 9'(s_now) || dut_a.hsv_wheel.region !== 9'(s_now / 60)
        || got !== exp) begin
      fails++;
      $display("FAIL sweep_edge%0d got step=%0d region=%0d rgb=%h exp step=%0d region=%0d rgb=%h",
        e, dut_a.hsv_wheel.step_counter, dut_a.hsv_wheel.region, got, s_now, s_now / 60, exp);
    end
  endtask

  task automatic test_step_timing();
    rst_n_a = 1'b1;
    for (int e = 1; e <= 300; e++) begin
      @(negedge clk);
      check_a_edge(e);
      if (e == 121) begin
        tests++;
        if ({dut_a.hsv_wheel.region, dut_a.hsv_wheel.red_value, dut_a.hsv_wheel.green_value,
             dut_a.hsv_wheel.blue_value} !== {9'd0, 8'd255, 8'd127, 8'd0}) begin
          fails++; $display("FAIL step30 got=%0d %0d/%0d/%0d exp=0 255/127/0",
            dut_a.hsv_wheel.region, dut_a.hsv_wheel.red_value,
            dut_a.hsv_wheel.green_value, dut_a.hsv_wheel.blue_value);
        end
      end
      if (e == 241) begin
        tests++;
        if ({dut_a.hsv_wheel.region, dut_a.hsv_wheel.red_value, dut_a.hsv_wheel.green_value,
             dut_a.hsv_wheel.blue_value} !== {9'd1, 8'd255, 8'd255, 8'd0}) begin
          fails++; $display("FAIL step60 got=%0d %0d/%0d/%0d exp=1 255/255/0",
            dut_a.hsv_wheel.region, dut_a.hsv_wheel.red_value,
            dut_a.hsv_wheel.green_value, dut_a.hsv_wheel.blue_value);
        end
      end
    end
  endtask

  task automatic test_wrap();
    int         wraps, bad_order;
    logic [8:0] prev_step, prev_region;
    wraps = 0; bad_order = 0;
    prev_step   = dut_a.hsv_wheel.step_counter;
    prev_region = dut_a.hsv_wheel.region;
    for (int e = 301; e <= 1445; e++) begin
      @(negedge clk);
      check_a_edge(e);
      if (prev_step == 9'd359 && dut_a.hsv_wheel.step_counter == 9'd0) wraps++;
      if (dut_a.hsv_wheel.region != prev_region &&
          dut_a.hsv_wheel.region != 9'((prev_region + 1) % 6)) bad_order++;
      prev_step   = dut_a.hsv_wheel.step_counter;
      prev_region = dut_a.hsv_wheel.region;
      if (e == 1437) begin
        tests++;
        if ({dut_a.hsv_wheel.region, dut_a.hsv_wheel.red_value, dut_a.hsv_wheel.green_value,
             dut_a.hsv_wheel.blue_value} !== {9'd5, 8'd255, 8'd0, 8'd5}) begin
          fails++; $display("FAIL step359 got=%0d %0d/%0d/%0d exp=5 255/0/5",
            dut_a.hsv_wheel.region, dut_a.hsv_wheel.red_value,
            dut_a.hsv_wheel.green_value, dut_a.hsv_wheel.blue_value);
        end
      end
      if (e == 1441) begin
        tests++;
        if ({dut_a.hsv_wheel.step_counter, dut_a.hsv_wheel.red_value,
             dut_a.hsv_wheel.green_value, dut_a.hsv_wheel.blue_value}
            !== {9'd0, 8'd255, 8'd0, 8'd0}) begin
          fails++; $display("FAIL wrap_to0 got=%0d %0d/%0d/%0d exp=0 255/0/0",
            dut_a.hsv_wheel.step_counter, dut_a.hsv_wheel.red_value,
            dut_a.hsv_wheel.green_value, dut_a.hsv_wheel.blue_value);
        end
      end
    end
    tests++;
    if (wraps != 1)     begin fails++; $display("FAIL wrap_count got=%0d exp=1", wraps); end
    tests++;
    if (bad_order != 0) begin fails++; $display("FAIL region_order got=%0d exp=0", bad_order); end
  endtask

  task automatic test_async_reset();
    rst_n_a = 1'b0;
    repeat (2) @(negedge clk);
    rst_n_a = 1'b1;
    repeat (800) @(negedge clk);
    tests++;
    if (dut_a.hsv_wheel.step_counter !== 9'd200 || a_b !== 1'b0) begin
      fails++; $display("FAIL pre_reset_step200 got=%0d b=%b exp=200 b=0",
        dut_a.hsv_wheel.step_counter, a_b);
    end
    #2 rst_n_a = 1'b0;
    #1;
    tests++;
    if ({a_r, a_g, a_b} !== 3'b111 || dut_a.hsv_wheel.step_counter !== 9'd0) begin
      fails++; $display("FAIL async_reset got rgb=%b step=%0d exp rgb=111 step=0",
        {a_r, a_g, a_b}, dut_a.hsv_wheel.step_counter);
    end
    tests++;
    if ({dut_a.hsv_wheel.red_value, dut_a.hsv_wheel.green_value, dut_a.hsv_wheel.blue_value}
        !== {8'd255, 8'd0, 8'd0} || dut_a.pwm_cnt !== 8'd0) begin
      fails++; $display("FAIL async_reset_values got=%0d/%0d/%0d pwm=%0d exp=255/0/0 pwm=0",
        dut_a.hsv_wheel.red_value, dut_a.hsv_wheel.green_value,
        dut_a.hsv_wheel.blue_value, dut_a.pwm_cnt);
    end
    @(negedge clk);
    rst_n_a = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      @(negedge clk);
      check_a_edge(e);
    end
  endtask

  task automatic test_region2_pwm();
    int r_low, g_low, b_low, guard;
    r_low = 0; g_low = 0; b_low = 0; guard = 0;
    while (p_edges < 38401 && guard < 50000) begin
      @(negedge clk);
      guard++;
    end
    tests++;
    if (p_edges != 38401) begin
      fails++; $display("FAIL region2_align got=%0d exp=38401", p_edges);
    end
    tests++;
    if (dut_p.hsv_wheel.step_counter !== 9'd150 || dut_p.hsv_wheel.region !== 9'd2) begin
      fails++; $display("FAIL step150 got=%0d region=%0d exp=150 region=2",
        dut_p.hsv_wheel.step_counter, dut_p.hsv_wheel.region);
    end
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (p_r === 1'b0) r_low++;
      if (p_g === 1'b0) g_low++;
      if (p_b === 1'b0) b_low++;
    end
    tests++;
    if (r_low != 0)   begin fails++; $display("FAIL region2_r_duty got=%0d exp=0", r_low); end
    tests++;
    if (g_low != 255) begin fails++; $display("FAIL region2_g_duty got=%0d exp=255", g_low); end
    tests++;
    if (b_low != 127) begin fails++; $display("FAIL region2_b_duty got=%0d exp=127", b_low); end
  endtask

  initial begin
    test_reset();
    test_release_pwm();
    test_step_timing();
    test_wrap();
    test_async_reset();
    test_region2_pwm();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
